// File: rtl/pc_sp_unit_pkg.sv
// Shared constants and helpers for the YASAC program counter / stack pointer
// datapath. The stack guard is controlled by the PCSP_STACK_GUARD_EN macro.
package pc_sp_unit_pkg;

    localparam int               PCSP_PC_W       = 8;
    localparam int               PCSP_DATA_W     = 8;
    localparam logic [7:0]       PCSP_SP_TOP     = 8'hFF;
    localparam int               PCSP_STACK_SIZE = 32;

    // Action taken on the program counter in one cycle.
    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_CLR   = 2'd1,
        PC_WRITE = 2'd2,
        PC_INC   = 2'd3
    } pc_op_t;

    // Resolves the PC strobes with priority CLR > WRITE > INC > hold.
    function automatic pc_op_t pc_decode(input logic clr, input logic write, input logic inc);
        if (clr)        return PC_CLR;
        else if (write) return PC_WRITE;
        else if (inc)   return PC_INC;
        else            return PC_HOLD;
    endfunction

endpackage

// File: rtl/pc_sp_unit_program_counter.sv
// Program counter register with its priority mux and load-value select.
// A load takes the low PC_W bits of MEM_DATA (RET) or ALU_RESULT (JMP/BRxx/CALL).
module program_counter
    import pc_sp_unit_pkg::*;
#(
    parameter int PC_W   = PCSP_PC_W,
    parameter int DATA_W = PCSP_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    input  logic              write,
    input  logic              read_mem,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    output logic [PC_W-1:0]   pc
);

    logic [DATA_W-1:0] load_wide;
    logic [PC_W-1:0]   load_value;
    pc_op_t            op;

    // Select the load source and resolve the strobe priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        load_wide  = read_mem ? mem_data : alu_result;
        load_value = PC_W'(load_wide);
        op         = pc_decode(clr, write, inc);
    end

    // PC register; synchronous reset overrides every strobe, INC wraps naturally.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
        if (reset) begin
            pc <= '0;
        end else begin
            unique case (op)
                PC_CLR:   pc <= '0;
                PC_WRITE: pc <= load_value;
                PC_INC:   pc <= pc + 1'b1;
                default:  pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/pc_sp_unit.sv
// Program counter and stack pointer datapath for YASAC.
// The stack grows downward: push is post-decrement, pop is pre-increment.
// Define PCSP_STACK_GUARD_EN to block pushes when full / pops when empty and
// raise the sticky STACK_OVF / STACK_UNF flags; otherwise SP simply wraps.
module pc_sp_unit
    import pc_sp_unit_pkg::*;
#(
    parameter int                PC_W       = PCSP_PC_W,
    parameter int                DATA_W     = PCSP_DATA_W,
    parameter logic [DATA_W-1:0] SP_TOP     = DATA_W'(PCSP_SP_TOP),
    parameter int                STACK_SIZE = PCSP_STACK_SIZE
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CLR_PROGCOUNT,
    input  logic              INC_PROGCOUNT,
    input  logic              WRITE_PROGCOUNT,
    input  logic              READ_PROGCOUNT,
    input  logic              PRESET_STACKPTR,
    input  logic              INC_STACKPTR,
    input  logic              DEC_STACKPTR,
    input  logic              READ_STACKPTR,
    input  logic              READ_MEM,
    input  logic [DATA_W-1:0] ALU_RESULT,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic [PC_W-1:0]   PC,
    output logic [DATA_W-1:0] BUS_OUT,
    output logic              BUS_OE,
    output logic [DATA_W-1:0] STACK_DEPTH,
    output logic              STACK_OVF,
    output logic              STACK_UNF
);

    logic [DATA_W-1:0] sp;
    logic              push;
    logic              pop;

    program_counter #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W)
    ) u_program_counter (
        .clk        (CLK),
        .reset      (RESET),
        .clr        (CLR_PROGCOUNT),
        .inc        (INC_PROGCOUNT),
        .write      (WRITE_PROGCOUNT),
        .read_mem   (READ_MEM),
        .alu_result (ALU_RESULT),
        .mem_data   (MEM_DATA),
        .pc         (PC)
    );

    // A simultaneous INC and DEC cancel out and hold SP.
    assign push = DEC_STACKPTR & ~INC_STACKPTR;
    assign pop  = INC_STACKPTR & ~DEC_STACKPTR;

    // Depth and bus drive follow the current registers; SP wins the bus over PC.
    always_comb begin
        STACK_DEPTH = SP_TOP - sp;
        BUS_OE      = READ_PROGCOUNT | READ_STACKPTR;
        BUS_OUT     = '0;
        if (READ_STACKPTR)       BUS_OUT = sp;
        else if (READ_PROGCOUNT) BUS_OUT = DATA_W'(PC);
    end

`ifdef PCSP_STACK_GUARD_EN
    logic full;
    logic empty;
    logic ovf_q;
    logic unf_q;

    assign full      = (STACK_DEPTH == DATA_W'(STACK_SIZE));
    assign empty     = (STACK_DEPTH == '0);
    assign STACK_OVF = ovf_q;
    assign STACK_UNF = unf_q;

    // SP and sticky flags: preset clears both, the guard blocks illegal moves.
    always_ff @(posedge CLK) begin
        if (RESET || PRESET_STACKPTR) begin
            sp    <= SP_TOP;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (push) begin
            if (full) ovf_q <= 1'b1;
            else      sp    <= sp - 1'b1;
        end else if (pop) begin
            if (empty) unf_q <= 1'b1;
            else       sp    <= sp + 1'b1;
        end
    end
`else
    assign STACK_OVF = 1'b0;
    assign STACK_UNF = 1'b0;

    // SP register, wrapping modulo 2**DATA_W.
    always_ff @(posedge CLK) begin
        if (RESET || PRESET_STACKPTR) sp <= SP_TOP;
        else if (push)                sp <= sp - 1'b1;
        else if (pop)                 sp <= sp + 1'b1;
    end
`endif

endmodule
